// File: rtl/axil_ipif_bridge.sv
// rtl/axil_ipif_bridge.sv - AXI4-Lite slave to single-BAR IPIF bridge, one transaction at a time.
// Optional data-phase timeout enabled by defining AXIL_IPIF_BRIDGE_TIMEOUT_EN.
module axil_ipif_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BAR0_BASEADDR = {C_S_AXI_ADDR_WIDTH{1'b1}},
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BAR0_HIGHADDR = '0,
  parameter int C_USE_WSTRB = 0,
  parameter int C_DPHASE_TIMEOUT = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            Bus2IP_Clk,
  output logic                            Bus2IP_Resetn,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr,
  output logic                            Bus2IP_CS,
  output logic                            Bus2IP_RNW,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data,
  input  logic                            IP2Bus_RdAck,
  input  logic                            IP2Bus_WrAck,
  input  logic                            IP2Bus_Error
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, RD_RESP, WR_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  state_t state, state_next;
  logic   pref_read;
  logic   rd_elig, wr_elig, grant_rd, grant_wr;
  logic   ar_in_bar, aw_in_bar, ack, timeout;
  logic [1:0] resp;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

  assign Bus2IP_Clk    = S_AXI_ACLK;
  assign Bus2IP_Resetn = S_AXI_ARESETN;

  assign rd_elig   = S_AXI_ARVALID;
  assign wr_elig   = S_AXI_AWVALID && S_AXI_WVALID;
  // On contention the type not granted last time wins.
  assign grant_rd  = (state == IDLE) && rd_elig && (!wr_elig || pref_read);
  assign grant_wr  = (state == IDLE) && wr_elig && !grant_rd;
  assign ar_in_bar = (S_AXI_ARADDR >= C_BAR0_BASEADDR) && (S_AXI_ARADDR <= C_BAR0_HIGHADDR);
  assign aw_in_bar = (S_AXI_AWADDR >= C_BAR0_BASEADDR) && (S_AXI_AWADDR <= C_BAR0_HIGHADDR);
  assign ack       = ((state == RD_WAIT) && IP2Bus_RdAck) || ((state == WR_WAIT) && IP2Bus_WrAck);

`ifdef AXIL_IPIF_BRIDGE_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)  tmo_cnt <= '0;
    else if (!Bus2IP_CS) tmo_cnt <= '0;
    else if (!ack)       tmo_cnt <= tmo_cnt + 8'd1;
  end

  // Fires in the last allowed CS cycle; a same-cycle ack takes priority.
  assign timeout = Bus2IP_CS && !ack && (tmo_cnt == 8'(C_DPHASE_TIMEOUT - 1));
`else
  assign timeout = 1'b0 && (C_DPHASE_TIMEOUT > 0);
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_rd)      state_next = ar_in_bar ? RD_WAIT : RD_RESP;
        else if (grant_wr) state_next = aw_in_bar ? WR_WAIT : WR_RESP;
      end
      RD_WAIT: if (ack || timeout) state_next = RD_RESP;
      WR_WAIT: if (ack || timeout) state_next = WR_RESP;
      RD_RESP: if (S_AXI_RREADY)   state_next = IDLE;
      WR_RESP: if (S_AXI_BREADY)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = grant_rd;
    S_AXI_AWREADY = grant_wr;
    S_AXI_WREADY  = grant_wr;
    Bus2IP_CS     = (state == RD_WAIT) || (state == WR_WAIT);
    Bus2IP_RNW    = (state == RD_WAIT);
    S_AXI_RVALID  = (state == RD_RESP);
    S_AXI_BVALID  = (state == WR_RESP);
    S_AXI_RDATA   = rdata;
    S_AXI_RRESP   = resp;
    S_AXI_BRESP   = resp;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      Bus2IP_Addr <= '0;
      Bus2IP_Data <= '0;
      Bus2IP_BE   <= '0;
      rdata       <= '0;
      resp        <= RESP_OKAY;
      pref_read   <= 1'b1;
    end else if (grant_rd) begin
      Bus2IP_Addr <= S_AXI_ARADDR;
      Bus2IP_BE   <= '1;
      rdata       <= '0;
      resp        <= ar_in_bar ? RESP_OKAY : RESP_DECERR;
      pref_read   <= 1'b0;
    end else if (grant_wr) begin
      Bus2IP_Addr <= S_AXI_AWADDR;
      Bus2IP_Data <= S_AXI_WDATA;
      Bus2IP_BE   <= (C_USE_WSTRB != 0) ? S_AXI_WSTRB : '1;
      resp        <= aw_in_bar ? RESP_OKAY : RESP_DECERR;
      pref_read   <= 1'b1;
    end else if (ack) begin
      if (state == RD_WAIT) rdata <= IP2Bus_Data;
      resp <= IP2Bus_Error ? RESP_SLVERR : RESP_OKAY;
    end else if (timeout) begin
      rdata <= '0;
      resp  <= RESP_SLVERR;
    end
  end

endmodule
